// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in small FIFOs and broadcasts one per cycle, round-robin.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int ROB_W     = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              is_clear,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [DATA_W-1:0] alu_val,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob_id,
  input  logic [DATA_W-1:0] lsb_val,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_id,
  output logic [DATA_W-1:0] cdb_val
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_W + DATA_W;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSB = 1'b1
  } prio_e;

  prio_e r_prio;
  prio_e w_prio_nxt;

  // Index 0 is the ALU source, index 1 is the LSB source.
  logic [ENT_W-1:0] r_mem [2][BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr [2];
  logic [PTR_W-1:0] r_rptr [2];
  logic [CNT_W-1:0] r_cnt [2];

  logic              r_cdb_valid;
  logic [ROB_W-1:0]  r_cdb_rob_id;
  logic [DATA_W-1:0] r_cdb_val;

  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_acc;
  logic [1:0]       w_bypass;
  logic [1:0]       w_cand;
  logic [1:0]       w_grant;
  logic [1:0]       w_enq;
  logic [1:0]       w_deq;
  logic [ENT_W-1:0] w_in [2];
  logic [ENT_W-1:0] w_cand_ent [2];
  logic [ENT_W-1:0] w_win;

  assign w_valid = {lsb_valid, alu_valid};
  assign w_in[0] = {alu_rob_id, alu_val};
  assign w_in[1] = {lsb_rob_id, lsb_val};

  // Readiness looks only at the registered count, so a dequeue this cycle does not open a slot.
  always_comb begin
    w_ready    = '0;
    w_acc      = '0;
    w_bypass   = '0;
    w_cand     = '0;
    w_cand_ent[0] = '0;
    w_cand_ent[1] = '0;
    for (int s = 0; s < 2; s++) begin
      w_ready[s] = !rst && rdy && (r_cnt[s] < CNT_W'(BUF_DEPTH));
      w_acc[s]   = w_valid[s] && w_ready[s] && !is_clear;
`ifdef CDB_BYPASS_EN
      w_bypass[s] = w_acc[s] && (r_cnt[s] == '0);
`else
      w_bypass[s] = 1'b0;
`endif
      w_cand[s]     = (r_cnt[s] != '0) || w_bypass[s];
      w_cand_ent[s] = (r_cnt[s] != '0) ? r_mem[s][r_rptr[s]] : w_in[s];
    end
  end

  always_comb begin
    w_grant    = '0;
    w_prio_nxt = r_prio;
    if (w_cand[0] && w_cand[1]) begin
      if (r_prio == PRIO_ALU) begin
        w_grant    = 2'b01;
        w_prio_nxt = PRIO_LSB;
      end else begin
        w_grant    = 2'b10;
        w_prio_nxt = PRIO_ALU;
      end
    end else begin
      w_grant = w_cand;
    end
    w_win = w_grant[1] ? w_cand_ent[1] : w_cand_ent[0];
  end

  // A granted bypass result goes straight to the bus and never occupies a slot.
  always_comb begin
    w_enq = '0;
    w_deq = '0;
    for (int s = 0; s < 2; s++) begin
      w_deq[s] = w_grant[s] && (r_cnt[s] != '0);
      w_enq[s] = w_acc[s] && !(w_bypass[s] && w_grant[s]);
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (w_enq[s]) begin
        r_mem[s][r_wptr[s]] <= w_in[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio       <= PRIO_ALU;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_val    <= '0;
      for (int s = 0; s < 2; s++) begin
        r_wptr[s] <= '0;
        r_rptr[s] <= '0;
        r_cnt[s]  <= '0;
      end
    end else if (rdy) begin
      if (is_clear) begin
        r_prio       <= PRIO_ALU;
        r_cdb_valid  <= 1'b0;
        r_cdb_rob_id <= '0;
        r_cdb_val    <= '0;
        for (int s = 0; s < 2; s++) begin
          r_wptr[s] <= '0;
          r_rptr[s] <= '0;
          r_cnt[s]  <= '0;
        end
      end else begin
        r_prio       <= w_prio_nxt;
        r_cdb_valid  <= |w_grant;
        r_cdb_rob_id <= (|w_grant) ? w_win[ENT_W-1 -: ROB_W] : '0;
        r_cdb_val    <= (|w_grant) ? w_win[DATA_W-1:0] : '0;
        for (int s = 0; s < 2; s++) begin
          if (w_enq[s]) begin
            r_wptr[s] <= r_wptr[s] + PTR_W'(1);
          end
          if (w_deq[s]) begin
            r_rptr[s] <= r_rptr[s] + PTR_W'(1);
          end
          if (w_enq[s] && !w_deq[s]) begin
            r_cnt[s] <= r_cnt[s] + CNT_W'(1);
          end else if (w_deq[s] && !w_enq[s]) begin
            r_cnt[s] <= r_cnt[s] - CNT_W'(1);
          end
        end
      end
    end
  end

  assign alu_ready  = w_ready[0];
  assign lsb_ready  = w_ready[1];
  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_val    = r_cdb_val;

endmodule
